// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, word-addressed instruction memory and a run/halt FSM.
// Combinational instruction read in RUN; a NOP is presented whenever fetching is gated off.
module instruction_fetch_unit #(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 6,
    parameter int PC_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [PC_W-1:0]   imm_offset,
    output logic [PC_W-1:0]   pc_out,
    output logic [31:0]       instruction,
    output logic [6:0]        opcode,
    output logic              fetch_valid,
    output logic              halted
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   target_pc;
    logic [31:0]       imem [IMEM_WORDS];
    logic [31:0]       mem_word;
    logic              take_branch;
    logic              out_of_range;
    logic              halt_cond;

    assign mem_word    = imem[pc[ADDR_W+1:2]];
    assign take_branch = Branch & Zero;
    assign target_pc   = take_branch ? pc + imm_offset : pc + PC_W'(4);
    // Any bit above the memory span set means past the end, including negative wrap.
    assign out_of_range = |target_pc[PC_W-1:ADDR_W+2];
    assign halt_cond    = (mem_word == 32'h0) || (target_pc[1:0] != 2'b00) || out_of_range;

    // Memory is deliberately outside the reset domain so a program survives reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_en) begin
            imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (halt_cond) begin
                    state_nxt = HALT;
                end else begin
                    pc_nxt = target_pc;
                end
            end
            HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    assign pc_out      = pc;
    assign instruction = (state == RUN) ? mem_word : NOP;
    assign opcode      = instruction[6:0];
    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed program runs, a branch vector table,
// and randomized traffic checked against a cycle-level reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        Branch;
    logic        Zero;
    logic [63:0] imm_offset;
    logic [63:0] pc_out;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic        fetch_valid;
    logic        halted;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halt.
    logic [31:0] m_mem [64];
    int          m_state;
    logic [63:0] m_pc;

    instruction_fetch_unit #(.IMEM_WORDS(64), .ADDR_W(6), .PC_W(64)) dut (
        .clk(clk), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .Branch(Branch),
        .Zero(Zero), .imm_offset(imm_offset), .pc_out(pc_out),
        .instruction(instruction), .opcode(opcode),
        .fetch_valid(fetch_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [31:0] w;
        logic [63:0] npc;
        case (m_state)
            0: begin
                if (load_en) m_mem[int'(load_addr)] = load_data;
                if (start) m_state = 1;
            end
            1: begin
                w   = m_mem[int'(m_pc >> 2)];
                npc = (Branch && Zero) ? m_pc + imm_offset : m_pc + 64'd4;
                if (w == 32'h0 || npc % 4 != 0 || npc >= 64'd256) m_state = 2;
                else m_pc = npc;
            end
            default: begin
                if (start) begin
                    m_pc    = 64'd0;
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic check(string nm);
        logic [31:0] ei;
        ei = (m_state == 1) ? m_mem[int'(m_pc >> 2)] : 32'h0000_0013;
        tests++;
        if (pc_out !== m_pc || instruction !== ei || opcode !== ei[6:0] ||
            fetch_valid !== (m_state == 1) || halted !== (m_state == 2)) begin
            fails++;
            $display("FAIL %s: got pc=%h instr=%h op=%h fv=%b hl=%b, want pc=%h instr=%h op=%h fv=%b hl=%b",
                     nm, pc_out, instruction, opcode, fetch_valid, halted,
                     m_pc, ei, ei[6:0], m_state == 1, m_state == 2);
        end
    endtask

    task automatic expect_io(string nm, logic [63:0] pc, logic fv, logic hl);
        tests++;
        if (pc_out !== pc || fetch_valid !== fv || halted !== hl) begin
            fails++;
            $display("FAIL %s: got pc=%h fv=%b hl=%b, want pc=%h fv=%b hl=%b",
                     nm, pc_out, fetch_valid, halted, pc, fv, hl);
        end
    endtask

    task automatic expect_instr(string nm, logic [31:0] w);
        tests++;
        if (instruction !== w || opcode !== w[6:0]) begin
            fails++;
            $display("FAIL %s: got instr=%h op=%h, want instr=%h op=%h",
                     nm, instruction, opcode, w, w[6:0]);
        end
    endtask

    // One clock: model advances on the same inputs the DUT sees, then compare.
    task automatic step(string nm);
        model_edge();
        @(posedge clk);
        #1;
        check(nm);
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        m_state = 0;
        m_pc    = 64'd0;
        check("reset_async");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_word(int a, logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 6'(a);
        load_data = d;
        step("load");
        load_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step("start");
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [63:0] start_pc;
        logic        br;
        logic        z;
        logic [63:0] off;
        logic [63:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{"br_back_taken",   64'd16,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8,   1'b0};
        vt[1] = '{"br_not_taken",    64'd16,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd20,  1'b0};
        vt[2] = '{"br_misaligned",   64'd4,   1'b1, 1'b1, 64'd2,                    64'd4,   1'b1};
        vt[3] = '{"br_out_of_range", 64'd0,   1'b1, 1'b1, 64'd256,                  64'd0,   1'b1};
        vt[4] = '{"seq_end_of_mem",  64'd252, 1'b0, 1'b0, 64'd0,                    64'd252, 1'b1};
        vt[5] = '{"br_neg_wrap",     64'd8,   1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8,   1'b1};
        vt[6] = '{"br_to_last_word", 64'd0,   1'b1, 1'b1, 64'd252,                  64'd252, 1'b0};

        for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
        start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        Branch = 1'b0; Zero = 1'b0; imm_offset = '0;
        m_state = 0; m_pc = 64'd0;

        reset = 1'b1;
        #2;
        check("reset_state");
        expect_io("reset_io", 64'd0, 1'b0, 1'b0);
        expect_instr("reset_nop", 32'h0000_0013);
        @(negedge clk);
        reset = 1'b0;

        // Four-word program ending in an all-zero word.
        load_word(0, 32'h0000_0093);
        load_word(1, 32'h0020_81B3);
        load_word(2, 32'h0000_A183);
        load_word(3, 32'h0000_0000);
        expect_io("idle_after_load", 64'd0, 1'b0, 1'b0);
        pulse_start();
        expect_io("run_pc0", 64'd0, 1'b1, 1'b0);
        expect_instr("run_word0", 32'h0000_0093);
        step("run"); expect_io("run_pc4", 64'd4, 1'b1, 1'b0);
        step("run"); expect_io("run_pc8", 64'd8, 1'b1, 1'b0);
        step("run"); expect_io("run_pc12", 64'd12, 1'b1, 1'b0);
        step("run"); expect_io("halt_zero_instr", 64'd12, 1'b0, 1'b1);

        // Loads in HALT are dropped; restart reads the original word 0.
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEAD_BEEF;
        step("halt_load");
        load_en = 1'b0;
        expect_io("halt_load_io", 64'd12, 1'b0, 1'b1);
        pulse_start();
        expect_io("restart_pc0", 64'd0, 1'b1, 1'b0);
        expect_instr("restart_orig_word", 32'h0000_0093);

        // Fill the whole memory with nonzero words.
        pulse_reset();
        for (int i = 0; i < 64; i++) load_word(i, 32'h0010_0093 + 32'(i));

        // Reset in the middle of a run, then rerun the retained program.
        pulse_start();
        repeat (5) step("run_to_20");
        expect_io("at_pc20", 64'd20, 1'b1, 1'b0);
        pulse_reset();
        expect_io("midrun_reset_io", 64'd0, 1'b0, 1'b0);
        tests++;
        if (opcode !== 7'b0010011) begin
            fails++;
            $display("FAIL midrun_reset_opcode: got %b want 0010011", opcode);
        end
        pulse_start();
        expect_instr("rerun_word0", 32'h0010_0093);
        step("rerun");
        expect_instr("rerun_word1", 32'h0010_0094);

        // Branch/boundary vector table.
        for (int v = 0; v < 7; v++) begin
            pulse_reset();
            pulse_start();
            repeat (int'(vt[v].start_pc >> 2)) step("advance");
            Branch = vt[v].br; Zero = vt[v].z; imm_offset = vt[v].off;
            step(vt[v].name);
            Branch = 1'b0; Zero = 1'b0; imm_offset = '0;
            expect_io(vt[v].name, vt[v].exp_pc, !vt[v].exp_halt, vt[v].exp_halt);
        end

        // Same-cycle load and start in IDLE: first fetch sees the new word.
        pulse_reset();
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h0050_0113; start = 1'b1;
        step("load_and_start");
        load_en = 1'b0; start = 1'b0;
        expect_io("load_start_io", 64'd0, 1'b1, 1'b0);
        expect_instr("load_start_word", 32'h0050_0113);

        // Randomized traffic against the model.
        pulse_reset();
        for (int i = 0; i < 64; i++)
            load_word(i, ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1));
        for (int c = 0; c < 3000; c++) begin
            int k;
            start     = ($urandom_range(0, 11) == 0);
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = 6'($urandom);
            load_data = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            Branch    = $urandom_range(0, 1) == 1;
            Zero      = $urandom_range(0, 1) == 1;
            k = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 7) == 0) imm_offset = {$urandom, $urandom};
            else if ($urandom_range(0, 7) == 0) imm_offset = 64'(k);
            else imm_offset = 64'(k * 4);
            step("random");
            if ($urandom_range(0, 299) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
